// File: rtl/fifo_read_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_read_streamer: FIFO read master feeding a valid/ready burst stream |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fifo_read_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int SKID_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [15:0]           word_count,
  output logic                  err_underflow,
  output logic                  busy
);

  localparam int PW = $clog2(SKID_DEPTH);
  localparam int OW = $clog2(SKID_DEPTH + 1);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [PW-1:0] PTR_MAX  = PW'(SKID_DEPTH - 1);
  localparam logic [OW:0]   DEPTH    = (OW + 1)'(SKID_DEPTH);
  localparam logic [BW-1:0] BEAT_MAX = BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [OW-1:0]         occ_q, occ_d;
  logic                  inflight_q;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [BW-1:0]         beat_q, beat_d;
  logic [15:0]           word_count_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] skid_q [SKID_DEPTH];
  logic                  pop;
  logic [OW:0]           level;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  assign m_valid       = (occ_q != '0);
  assign m_data        = skid_q[rd_ptr_q];
  assign pop           = m_valid && m_ready;
  assign m_last        = m_valid && (beat_q == BEAT_MAX);
  assign word_count    = word_count_q;
  assign err_underflow = err_q;
  assign busy          = (state_q != IDLE) || m_valid;

  // Space still free once the pending capture lands and this cycle's pop leaves;
  // the m_ready term lets a full buffer keep one word per cycle flowing.
  assign level      = {1'b0, occ_q} + {{OW{1'b0}}, inflight_q} - {{OW{1'b0}}, pop};
  assign fifo_rd_en = (state_q == RUN) && !fifo_empty && (level < DEPTH);

  always_comb begin
    state_d = state_q;
    occ_d   = occ_q;
    beat_d  = beat_q;

    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = STOP;
      STOP:    if (!inflight_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case ({inflight_q, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    if (pop) beat_d = (beat_q == BEAT_MAX) ? '0 : beat_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      occ_q        <= '0;
      inflight_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      beat_q       <= '0;
      word_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en;
      beat_q     <= beat_d;
      if (inflight_q) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop) begin
        rd_ptr_q     <= ptr_inc(rd_ptr_q);
        word_count_q <= word_count_q + 16'd1;
      end
      if (fifo_underflow) err_q <= 1'b1;
    end
  end

  // Payload storage needs no reset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (inflight_q) skid_q[wr_ptr_q] <= fifo_data_out;
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_streamer.sv
`default_nettype none
// Directed bench for fifo_read_streamer with a behavioural registered-output FIFO.
module tb_fifo_read_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        fifo_underflow = 1'b0;
  logic        fifo_empty;
  logic [15:0] fifo_data_out = '0;
  logic        fifo_rd_en;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [15:0] m_data;
  logic        m_last;
  logic [15:0] word_count;
  logic        err_underflow;
  logic        busy;
  logic        fifo_flush = 1'b0;

  int vectors = 0;
  int errors  = 0;

  logic [15:0] fmem [0:255];
  int          wr_idx = 0;
  int          rd_idx = 0;

  logic [15:0] got [$];
  logic        lastq [$];
  int          outst = 0;
  int          occ_viol = 0;
  int          empty_viol = 0;

  always #5 clk = ~clk;

  fifo_read_streamer #(.DATA_WIDTH(16), .BURST_LEN(4), .SKID_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty),
    .fifo_underflow(fifo_underflow), .fifo_data_out(fifo_data_out),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .word_count(word_count),
    .err_underflow(err_underflow), .busy(busy)
  );

  assign fifo_empty = (rd_idx == wr_idx);

  always @(posedge clk) begin
    if (fifo_flush) rd_idx <= wr_idx;
    else if (fifo_rd_en && !fifo_empty) begin
      fifo_data_out <= fmem[rd_idx[7:0]];
      rd_idx        <= rd_idx + 1;
    end
  end

  // Outstanding = reads issued minus words delivered = skid occupancy + inflight.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) outst <= 0;
    else begin
      if (outst > 2) occ_viol <= occ_viol + 1;
      if (fifo_rd_en && fifo_empty) empty_viol <= empty_viol + 1;
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        lastq.push_back(m_last);
      end
      outst <= outst + (fifo_rd_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
    end
  end

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] w);
    fmem[wr_idx[7:0]] = w;
    wr_idx = wr_idx + 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; m_ready = 1'b1; fifo_underflow = 1'b0; fifo_flush = 1'b1;
    repeat (2) @(negedge clk);
    nx();
    rst_n = 1'b1; fifo_flush = 1'b0;
  endtask

  task automatic wait_words(input int target, input string name);
    for (int c = 0; c < 80 && got.size() < target; c++) @(posedge clk);
    #1;
    vectors++;
    if (got.size() < target) begin
      errors++;
      $display("FAIL %s_timeout: delivered %0d words, required %0d", name, got.size(), target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({m_valid, m_last, fifo_rd_en, busy, err_underflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: valid/last/rd/busy/err=%b required 00000",
               {m_valid, m_last, fifo_rd_en, busy, err_underflow});
    end
    vectors++;
    if (word_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_count: word_count=%0d required 0", word_count);
    end
    do_reset();
  endtask

  task automatic test_latency();
    logic [9:0]  rdv, pv;
    logic [15:0] dv [10];
    logic [15:0] exp_d [3];
    exp_d = '{16'h0011, 16'h0022, 16'h0033};
    do_reset();
    load(16'h0011); load(16'h0022); load(16'h0033);
    nx();
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rdv[i] = fifo_rd_en;
      pv[i]  = m_valid && m_ready;
      dv[i]  = m_data;
    end
    vectors++;
    if (rdv !== 10'b0000001110) begin
      errors++;
      $display("FAIL latency_rd_en: pattern=%b required 0000001110", rdv);
    end
    vectors++;
    if (pv !== 10'b0000111000) begin
      errors++;
      $display("FAIL latency_valid: pattern=%b required 0000111000", pv);
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (dv[3+k] !== exp_d[k]) begin
        errors++;
        $display("FAIL latency_data%0d: m_data=%h required %h", k, dv[3+k], exp_d[k]);
      end
    end
    vectors++;
    if (word_count !== 16'd3) begin
      errors++;
      $display("FAIL latency_count: word_count=%0d required 3", word_count);
    end
    en = 1'b0;
    repeat (4) nx();
  endtask

  task automatic test_burst();
    int          base;
    logic [9:0]  lv;
    int          bad;
    do_reset();
    base = got.size();
    for (int i = 0; i < 10; i++) load(16'h0100 + 16'(i));
    nx();
    en = 1'b1;
    wait_words(base + 10, "burst");
    bad = 0;
    lv = '0;
    for (int i = 0; i < 10 && base + i < got.size(); i++) begin
      lv[i] = lastq[base+i];
      if (got[base+i] !== 16'h0100 + 16'(i)) bad++;
    end
    vectors++;
    if (lv !== 10'b0010001000) begin
      errors++;
      $display("FAIL burst_last: last pattern=%b required 0010001000", lv);
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL burst_order: %0d words out of order, required 0", bad);
    end
    vectors++;
    if (word_count !== 16'd10) begin
      errors++;
      $display("FAIL burst_count: word_count=%0d required 10", word_count);
    end
    load(16'h010A); load(16'h010B);
    wait_words(base + 12, "burst_tail");
    vectors++;
    if (got.size() >= base + 12 && {lastq[base+10], lastq[base+11]} !== 2'b01) begin
      errors++;
      $display("FAIL burst_wrap: last on words 11,12=%b required 01",
               {lastq[base+10], lastq[base+11]});
    end
    en = 1'b0;
    repeat (4) nx();
  endtask

  task automatic test_back_to_back();
    int base, rdc, hold_bad, bad;
    do_reset();
    base = got.size();
    for (int i = 0; i < 8; i++) load(16'h0200 + 16'(i));
    m_ready = 1'b0;
    nx();
    en = 1'b1;
    rdc = 0; hold_bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (fifo_rd_en) rdc++;
      if (m_valid && (m_data !== 16'h0200 || m_last !== 1'b0)) hold_bad++;
    end
    vectors++;
    if (rdc != 2) begin
      errors++;
      $display("FAIL stall_reads: %0d reads during stall, required 2", rdc);
    end
    vectors++;
    if (m_valid !== 1'b1 || hold_bad != 0) begin
      errors++;
      $display("FAIL stall_hold: m_valid=%b unstable=%0d required valid=1 unstable=0",
               m_valid, hold_bad);
    end
    nx();
    m_ready = 1'b1;
    wait_words(base + 8, "stall");
    bad = 0;
    for (int i = 0; i < 8 && base + i < got.size(); i++)
      if (got[base+i] !== 16'h0200 + 16'(i)) bad++;
    vectors++;
    if (bad != 0 || got.size() != base + 8) begin
      errors++;
      $display("FAIL stall_order: %0d bad words, %0d delivered, required 0 bad and 8",
               bad, got.size() - base);
    end
    vectors++;
    if (word_count !== 16'd8) begin
      errors++;
      $display("FAIL stall_count: word_count=%0d required 8", word_count);
    end
    en = 1'b0;
    repeat (4) nx();
  endtask

  task automatic test_stop();
    int         base, bad;
    logic [7:0] rdv, bv;
    do_reset();
    base = got.size();
    for (int i = 0; i < 6; i++) load(16'h0300 + 16'(i));
    nx();
    en = 1'b1;
    nx();
    nx();
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rdv[i] = fifo_rd_en;
      bv[i]  = busy;
    end
    vectors++;
    if (rdv !== 8'b00000001) begin
      errors++;
      $display("FAIL stop_rd_en: pattern=%b required 00000001", rdv);
    end
    vectors++;
    if (bv !== 8'b00000111) begin
      errors++;
      $display("FAIL stop_busy: pattern=%b required 00000111", bv);
    end
    vectors++;
    if (got.size() != base + 2 || wr_idx - rd_idx != 4) begin
      errors++;
      $display("FAIL stop_words: delivered=%0d left=%0d required delivered=2 left=4",
               got.size() - base, wr_idx - rd_idx);
    end
    nx();
    en = 1'b1;
    wait_words(base + 6, "stop_resume");
    bad = 0;
    for (int i = 0; i < 6 && base + i < got.size(); i++)
      if (got[base+i] !== 16'h0300 + 16'(i)) bad++;
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stop_resume_order: %0d bad words, required 0", bad);
    end
    en = 1'b0;
    repeat (4) nx();
  endtask

  task automatic test_underflow();
    do_reset();
    vectors++;
    if (err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL uf_initial: err_underflow=%b required 0", err_underflow);
    end
    nx();
    fifo_underflow = 1'b1;
    nx();
    fifo_underflow = 1'b0;
    repeat (5) nx();
    @(negedge clk);
    vectors++;
    if (err_underflow !== 1'b1) begin
      errors++;
      $display("FAIL uf_sticky: err_underflow=%b required 1", err_underflow);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL uf_clear: err_underflow=%b required 0", err_underflow);
    end
    do_reset();
  endtask

  task automatic test_async_reset();
    int base, wc_exp, rd_seen;
    do_reset();
    base = got.size();
    for (int i = 0; i < 8; i++) load(16'h0400 + 16'(i));
    nx();
    en = 1'b1;
    wait_words(base + 2, "areset");
    m_ready = 1'b0;
    wc_exp = got.size() - base;
    repeat (4) nx();
    @(negedge clk);
    vectors++;
    if (m_valid !== 1'b1 || busy !== 1'b1 || word_count !== 16'(wc_exp)) begin
      errors++;
      $display("FAIL areset_pre: valid=%b busy=%b count=%0d required 1 1 %0d",
               m_valid, busy, word_count, wc_exp);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({m_valid, busy, m_last} !== 3'b000 || word_count !== 16'd0) begin
      errors++;
      $display("FAIL areset_now: valid/busy/last=%b count=%0d required 000 and 0",
               {m_valid, busy, m_last}, word_count);
    end
    rd_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (fifo_rd_en) rd_seen++;
    end
    vectors++;
    if (rd_seen != 0) begin
      errors++;
      $display("FAIL areset_rd: %0d reads during reset, required 0", rd_seen);
    end
    do_reset();
  endtask

  task automatic test_rules();
    repeat (2) nx();
    vectors++;
    if (occ_viol != 0) begin
      errors++;
      $display("FAIL occupancy: %0d cycles above depth 2, required 0", occ_viol);
    end
    vectors++;
    if (empty_viol != 0) begin
      errors++;
      $display("FAIL read_on_empty: %0d reads while empty, required 0", empty_viol);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_burst();
    test_back_to_back();
    test_stop();
    test_underflow();
    test_async_reset();
    test_rules();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/fifo_read_streamer.md
Name: fifo_read_streamer

Overview:
- Read-side master for the team's synchronous FIFO.
- Watches the FIFO's empty flag, issues rd_en, and captures the registered data_out one cycle later into a small skid buffer.
- Presents the words on a valid/ready stream interface with burst framing (m_last).
- Sits between the FIFO and any downstream consumer that can stall; sustains one word per cycle when the consumer is always ready.

Parameters:
- DATA_WIDTH, 16, width of FIFO words and m_data.
- BURST_LEN, 4, words per burst; m_last marks every BURST_LEN-th delivered word (legal range 1..256).
- SKID_DEPTH, 2, skid-buffer entries (legal range 2..8).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  1 = stream from FIFO; 0 = stop issuing reads.
- fifo_empty  in  1  FIFO empty flag.
- fifo_underflow  in  1  FIFO underflow flag.
- fifo_data_out  in  DATA_WIDTH  FIFO read data; valid the cycle after an accepted rd_en.
- fifo_rd_en  out  1  read request to FIFO (combinational).
- m_valid  out  1  m_data holds a word.
- m_ready  in  1  consumer accepts the word this cycle.
- m_data  out  DATA_WIDTH  head of skid buffer.
- m_last  out  1  current word is the last of a burst.
- word_count  out  16  words delivered (m_valid&&m_ready), wraps modulo 2^16.
- err_underflow  out  1  sticky; set when fifo_underflow is seen high.
- busy  out  1  state!=IDLE or skid buffer non-empty.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; occupancy, inflight, skid pointers, beat counter, word_count and err_underflow all cleared.
  - Outputs: m_valid=0, m_last=0, fifo_rd_en=0, busy=0.
  - Reset mid-stream discards in-flight and buffered words; the FIFO's own pointers are not touched.
- Definitions:
  - pop = m_valid && m_ready.
  - occ = skid occupancy (0..SKID_DEPTH).
  - inflight = 1-bit register, 1 when a read was issued last cycle.
- fifo_rd_en = (state==RUN) && !fifo_empty && (occ + inflight - pop < SKID_DEPTH).
  - Combinational path from m_ready to fifo_rd_en is intentional.
  - No read is ever issued while fifo_empty=1.
- inflight <= fifo_rd_en every cycle.
- When inflight=1, fifo_data_out is written at the tail the same edge.
  - Simultaneous write and pop: occ unchanged, both pointers advance.
  - Pointers wrap at SKID_DEPTH.
  - Overflowing the skid buffer is impossible by construction; the bench asserts occ<=SKID_DEPTH.
- m_valid = (occ!=0). m_data = entry at head.
  - While m_valid=1 and m_ready=0, m_data and m_last are held stable.
- Latency: FIFO non-empty with en=1, RUN, consumer ready → first m_valid two cycles after fifo_rd_en first asserts (read edge, capture edge). Steady state: 1 word/cycle.
- Beat counter 0..BURST_LEN-1, advances on pop, wraps to 0 after BURST_LEN-1.
  - m_last = m_valid && (beat==BURST_LEN-1).
  - BURST_LEN=1: m_last = m_valid.
- word_count increments on pop.
- FSM:
  - IDLE: en=1 → RUN.
  - RUN: issue reads per rule above; en=0 → STOP.
  - STOP: no reads. inflight=0 → IDLE (the capture completes first if a read is pending).
  - Buffered words keep draining to the consumer in every state.
  - en toggling 1→0→1 within STOP: stay in STOP until inflight=0, then IDLE, then RUN next cycle.
- err_underflow: set on any cycle with fifo_underflow=1; cleared only by reset. Never caused by this block; flags another agent reading the FIFO.

Test Plan:
- Reset, FIFO holds 0x0011,0x0022,0x0033 (empty=1 after 3 reads), en=1, m_ready=1 → fifo_rd_en high 3 consecutive cycles; m_data 0x0011,0x0022,0x0033 on consecutive cycles starting 2 cycles after first rd_en; word_count=3.
- BURST_LEN=4, 10 words, m_ready=1 → m_last high on words 4 and 8 only; beat=2 at end; word_count=10.
- 8 words, m_ready=0 for 6 cycles then 1 → at most SKID_DEPTH=2 reads issued during stall; m_data held stable; no word lost or duplicated after release; order preserved.
- en dropped while fifo_rd_en=1 → exactly one more capture; STOP then IDLE; remaining words stay in FIFO; busy falls after buffer drains.
- Force fifo_underflow=1 for one cycle → err_underflow=1 and stays 1 until rst_n pulse.
- rst_n pulsed low asynchronously (mid-clock) with occ=2 → m_valid, busy, word_count go 0 immediately; no read issued during reset.
